dense_in_packer: RTL
====================

DENSE_IN_PACKER -- requirements
Module: dense_in_packer

Interface
REQ-001 Parameter: fixed, default 32, word width in bits (feature/activation word).
REQ-002 Parameter: nb_input, default 42, words per packed vector (dense-layer input count M).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: s_valid  input  1  upstream word valid.
REQ-006 Port: s_ready  output  1  packer can accept a word.
REQ-007 Port: s_data  input  fixed  upstream word.
REQ-008 Port: s_last  input  1  marks final word of a frame.
REQ-009 Port: vec_valid  output  1  packed vector complete and held.
REQ-010 Port: vec_ready  input  1  dense layer accepts the vector.
REQ-011 Port: vec_data  output  nb_input*fixed  packed vector: word k at bits [k*fixed +: fixed].
REQ-012 Port: err_short  output  1  one-cycle pulse: s_last before word nb_input-1.
REQ-013 Port: err_nolast  output  1  one-cycle pulse: word nb_input-1 accepted without s_last.
REQ-014 Port: frame_cnt  output  16  count of vectors delivered (handshakes on vec side).

Function
REQ-015 Two states SHALL exist: FILL (collecting words) and FULL (vector held for consumer).
REQ-016 Word transfer SHALL occur on a rising edge where s_valid && s_ready; no transfer otherwise.
REQ-017 s_ready SHALL be 1 in FILL and 0 in FULL (no bypass, no double buffering).
REQ-018 A word index counter idx (width ceil(log2(nb_input))) SHALL address the write slot; transferred s_data SHALL be written to vec_data word idx, all other words unchanged.
REQ-019 On transfer with idx < nb_input-1 and s_last=0, idx SHALL increment.
REQ-020 On transfer with idx < nb_input-1 and s_last=1: partial frame discarded, idx -> 0, err_short pulses 1 cycle next edge, state stays FILL, vec_valid stays 0.
REQ-021 On transfer with idx = nb_input-1: state -> FULL, idx -> 0, vec_valid = 1 from next cycle; if s_last=0, err_nolast pulses 1 cycle (vector still delivered).
REQ-022 Latency: last word accepted at edge t -> vec_valid high and vec_data complete after edge t, i.e. visible in cycle t+1.
REQ-023 In FULL, vec_valid and vec_data SHALL hold stable until a rising edge with vec_ready=1.
REQ-024 On edge in FULL with vec_ready=1: state -> FILL, vec_valid -> 0, frame_cnt increments by 1 (wraps 0xFFFF -> 0x0000), s_ready = 1 from next cycle.
REQ-025 vec_ready SHALL be ignored in FILL; s_valid/s_data/s_last SHALL be ignored in FULL.
REQ-026 vec_data contents after handshake SHALL remain as last written until overwritten word by word; consumers SHALL sample only while vec_valid=1.
REQ-027 Data is raw bits; no arithmetic, sign or format conversion is applied to words.
REQ-028 err_short and err_nolast SHALL never both be 1 in the same cycle.

Reset
REQ-029 While rst_n=0 (asynchronously): state=FILL, idx=0, vec_valid=0, err_short=0, err_nolast=0, frame_cnt=0, vec_data=all zeros; s_ready=0 while in reset, 1 from first edge after release.
REQ-030 Reset asserted mid-frame or in FULL SHALL discard the frame with no error pulse and no frame_cnt change.

Verification
REQ-031 Normal frame: 42 words 0x00000001..0x0000002A back-to-back, s_last on 42nd, vec_ready=0 -> vec_valid=1 cycle after 42nd word, word k = k+1, s_ready=0, no errors.
REQ-032 Hold and release: vector held 10 cycles, vec_ready=1 one cycle -> vec_valid=0, frame_cnt=1, s_ready=1 next cycle; vec_data unchanged during hold.
REQ-033 Short frame: s_last on 5th word -> err_short single pulse, vec_valid stays 0; following full 42-word frame delivered correctly.
REQ-034 Missing last: 42 words with s_last=0 -> err_nolast single pulse, vec_valid=1, data correct.
REQ-035 Gapped input: s_valid toggled randomly; words offered while in FULL not accepted -> vector matches accepted words only, frame_cnt increments once per vec handshake, wraps after 65536 frames (forced).
REQ-036 Reset mid-frame: rst_n low after 20 words -> all outputs at reset values immediately, next 42-word frame delivered with no errors and frame_cnt=1 after handshake.

Source files
------------

// File: rtl/dense_in_packer.sv
// Collects a frame of nb_input words from a valid/ready stream into one wide vector
// and holds it until the dense layer takes it; flags short and unterminated frames.
module dense_in_packer #(
   parameter int fixed    = 32,
   parameter int nb_input = 42
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [fixed-1:0]             s_data,
   input  logic                         s_last,
   output logic                         vec_valid,
   input  logic                         vec_ready,
   output logic [nb_input*fixed-1:0]    vec_data,
   output logic                         err_short,
   output logic                         err_nolast,
   output logic [15:0]                  frame_cnt
);

   localparam int IDX_W = (nb_input > 1) ? $clog2(nb_input) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(nb_input - 1);

   typedef enum logic {FILL, FULL} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             live_q;
   logic             short_d, nolast_d;
   logic             xfer, vec_hs;
   logic [15:0]      frame_cnt_q;

   // live_q keeps s_ready low until the first edge after reset release
   assign s_ready   = live_q && (state_q == FILL);
   assign vec_valid = (state_q == FULL);
   assign xfer      = s_valid && s_ready;
   assign vec_hs    = (state_q == FULL) && vec_ready;
   assign frame_cnt = frame_cnt_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      short_d  = 1'b0;
      nolast_d = 1'b0;
      case (state_q)
         FILL: begin
            if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  state_d  = FULL;
                  idx_d    = '0;
                  nolast_d = !s_last;
               end else if (s_last) begin
                  idx_d   = '0;
                  short_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (vec_ready) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         idx_q       <= '0;
         live_q      <= 1'b0;
         err_short   <= 1'b0;
         err_nolast  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         live_q      <= 1'b1;
         err_short   <= short_d;
         err_nolast  <= nolast_d;
         if (vec_hs) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   // Slots not written by the current frame keep their previous contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_data <= '0;
      end else if (xfer) begin
         vec_data[int'(idx_q)*fixed +: fixed] <= s_data;
      end
   end

endmodule
